// File: rtl/seg_scan6.sv
// Six-digit multiplexed 7-segment scanner for a HH:MM:SS clock display.
// Time-multiplexes BCD digits with leading-zero suppression, field blinking and a blinking colon.
module seg_scan6 #(
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic        CP,
    input  logic        nCLR,
    input  logic        EN,
    input  logic [23:0] D,
    input  logic        BLANK_LZ,
    input  logic [1:0]  BLINK_SEL,
    output logic [5:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int              PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [9:0]      BLINK_LAST = 10'(BLINK_TICKS - 1);

    logic [PW-1:0] presc_reg, presc_next;
    logic [2:0]    ptr_reg, ptr_next;
    logic [9:0]    blink_reg, blink_next;
    logic          phase_reg, phase_next;
    logic [5:0]    an_reg, an_next;
    logic [6:0]    seg_reg, seg_next;
    logic          dp_reg, dp_next;

    logic          tick;
    logic          blink_wrap;
    logic          lz_blank;
    logic          blink_blank;
    logic [3:0]    cur_digit;
    logic [3:0]    digit [8];

    // Pad the digit table to 8 entries so the 3-bit pointer indexes it cleanly.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            if (gi < 6) begin : g_live
                assign digit[gi] = D[gi*4 +: 4];
            end else begin : g_pad
                assign digit[gi] = 4'h0;
            end
        end
    endgenerate

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        tick       = EN && (presc_reg == PRESC_LAST);
        blink_wrap = tick && (blink_reg == BLINK_LAST);

        presc_next = presc_reg;
        if (EN) begin
            presc_next = tick ? '0 : presc_reg + 1'b1;
        end

        ptr_next   = ptr_reg;
        blink_next = blink_reg;
        if (tick) begin
            ptr_next   = (ptr_reg == 3'd5) ? 3'd0 : ptr_reg + 3'd1;
            blink_next = blink_wrap ? 10'd0 : blink_reg + 10'd1;
        end
        phase_next = phase_reg ^ blink_wrap;

        // Field pairs are {0,1},{2,3},{4,5}, so ptr[2:1] names the field.
        cur_digit   = digit[ptr_reg];
        lz_blank    = BLANK_LZ && (ptr_reg == 3'd5) && (D[23:20] == 4'h0);
        blink_blank = phase_reg && (BLINK_SEL != 2'd0) && (ptr_reg[2:1] == BLINK_SEL - 2'd1);

        an_next  = 6'h3F;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (EN && !lz_blank && !blink_blank) begin
            an_next  = ~(6'b000001 << ptr_reg);
            seg_next = bcd_to_seg(cur_digit);
            dp_next  = !(!phase_reg && ((ptr_reg == 3'd2) || (ptr_reg == 3'd4)));
        end
    end

    always_ff @(posedge CP or negedge nCLR) begin
        if (!nCLR) begin
            presc_reg <= '0;
            ptr_reg   <= 3'd0;
            blink_reg <= 10'd0;
            phase_reg <= 1'b0;
            an_reg    <= 6'h3F;
            seg_reg   <= 7'h7F;
            dp_reg    <= 1'b1;
        end else begin
            presc_reg <= presc_next;
            ptr_reg   <= ptr_next;
            blink_reg <= blink_next;
            phase_reg <= phase_next;
            an_reg    <= an_next;
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
        end
    end

    assign AN  = an_reg;
    assign SEG = seg_reg;
    assign DP  = dp_reg;

endmodule

// File: tb/tb_seg_scan6.sv
// Scoreboard bench for seg_scan6: driver pushes expected outputs from a count-based model,
// monitor pops and compares one entry per CP cycle.
module tb_seg_scan6;

    localparam int SD = 4;
    localparam int BT = 2;

    logic        CP = 1'b0;
    logic        nCLR;
    logic        EN;
    logic [23:0] D;
    logic        BLANK_LZ;
    logic [1:0]  BLINK_SEL;
    logic [5:0]  AN;
    logic [6:0]  SEG;
    logic        DP;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    exp_t        mon_g;
    int          checks   = 0;
    int          failures = 0;
    int          txn      = 0;
    int          n        = 0;
    logic [6:0]  seg_lut [16];

    logic        en_s;
    logic [23:0] d_s;
    logic        blz_s;
    logic [1:0]  sel_s;

    seg_scan6 #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
        .CP(CP), .nCLR(nCLR), .EN(EN), .D(D), .BLANK_LZ(BLANK_LZ),
        .BLINK_SEL(BLINK_SEL), .AN(AN), .SEG(SEG), .DP(DP)
    );

    always #5 CP = ~CP;

    // n = enabled cycles since reset; everything else follows by division.
    function automatic exp_t model_out();
        exp_t        e;
        int          ticks, ptr, ph;
        logic [23:0] dv;
        logic [3:0]  nib;
        e = '{an: 6'h3F, seg: 7'h7F, dp: 1'b1};
        if (nCLR !== 1'b1 || EN !== 1'b1) return e;
        ticks = n / SD;
        ptr   = ticks % 6;
        ph    = (ticks / BT) % 2;
        dv    = D;
        nib   = dv[ptr*4 +: 4];
        if (BLANK_LZ && ptr == 5 && dv[23:20] == 4'h0) return e;
        if (ph == 1 && BLINK_SEL != 2'd0 && (ptr / 2) == int'(BLINK_SEL) - 1) return e;
        e.an  = ~(6'(1) << ptr);
        e.seg = seg_lut[nib];
        e.dp  = (ph == 0 && (ptr == 2 || ptr == 4)) ? 1'b0 : 1'b1;
        return e;
    endfunction

    task automatic step();
        EN        = en_s;
        D         = d_s;
        BLANK_LZ  = blz_s;
        BLINK_SEL = sel_s;
        exp_q.push_back(model_out());
        if (nCLR !== 1'b1) n = 0;
        else if (EN) n++;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge CP);
            step();
        end
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end else begin
            $display("chk %s got=%h ok", name, got);
        end
    endtask

    // Asynchronous reset between edges: outputs must blank before any CP edge.
    task automatic reset_pulse();
        @(negedge CP);
        #1 nCLR = 1'b0;
        #1;
        check("async_rst_an", {2'b0, AN}, 8'h3F);
        check("async_rst_seg", {1'b0, SEG}, 8'h7F);
        check("async_rst_dp", {7'b0, DP}, 8'h01);
        #1 nCLR = 1'b1;
        n = 0;
        step();
    endtask

    task automatic rand_cycle();
        @(negedge CP);
        en_s = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 7) == 0) begin
            for (int k = 0; k < 6; k++) d_s[k*4 +: 4] = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 2) == 0) d_s[23:20] = 4'h0;
        end
        if ($urandom_range(0, 15) == 0) blz_s = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) sel_s = 2'($urandom_range(0, 3));
        step();
    endtask

    always @(posedge CP) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_g = '{an: AN, seg: SEG, dp: DP};
            checks++;
            txn++;
            if (mon_g !== mon_e) begin
                failures++;
                $display("FAIL scan[%0d] got an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         txn, mon_g.an, mon_g.seg, mon_g.dp, mon_e.an, mon_e.seg, mon_e.dp);
            end else begin
                $display("txn %0d an=%h seg=%h dp=%b ok", txn, mon_g.an, mon_g.seg, mon_g.dp);
            end
        end
    end

    initial begin
        seg_lut[0]  = 7'h40; seg_lut[1]  = 7'h79; seg_lut[2]  = 7'h24; seg_lut[3]  = 7'h30;
        seg_lut[4]  = 7'h19; seg_lut[5]  = 7'h12; seg_lut[6]  = 7'h02; seg_lut[7]  = 7'h78;
        seg_lut[8]  = 7'h00; seg_lut[9]  = 7'h10;
        for (int i = 10; i < 16; i++) seg_lut[i] = 7'h3F;

        nCLR = 1'b0; EN = 1'b0; D = 24'h0; BLANK_LZ = 1'b0; BLINK_SEL = 2'd0;
        en_s = 1'b0; d_s = 24'h0; blz_s = 1'b0; sel_s = 2'd0;
        repeat (2) @(posedge CP);
        #1;
        check("reset_an", {2'b0, AN}, 8'h3F);
        check("reset_seg", {1'b0, SEG}, 8'h7F);
        check("reset_dp", {7'b0, DP}, 8'h01);
        run(2);

        // Scan order with all digits visible.
        en_s = 1'b1; d_s = 24'h123456; blz_s = 1'b0; sel_s = 2'd0;
        @(negedge CP);
        nCLR = 1'b1;
        step();
        run(30);

        // Leading-zero blanking.
        d_s = 24'h091500; blz_s = 1'b1;
        run(30);

        // Minutes field blink.
        sel_s = 2'd2;
        run(60);

        // Freeze at pointer 3 mid-count.
        sel_s = 2'd0; blz_s = 1'b0; d_s = 24'h123456;
        for (int i = 0; i < 100 && !(((n / SD) % 6) == 3 && (n % SD) == 1); i++) run(1);
        en_s = 1'b0;
        run(10);
        en_s = 1'b1;
        run(20);

        // Invalid BCD then asynchronous reset pulse.
        d_s = 24'h12345C;
        run(30);
        reset_pulse();
        run(30);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) reset_pulse();
            else rand_cycle();
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CP);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
